// File: rtl/queue_param_fifo_1w_2r.sv
`default_nettype none
// ============================================================================
//  Module      : queue_param_fifo_1w_2r
//  Description : Parametrised circular FIFO with one write port and two
//                combinational read ports (head and head+1). Consumers may
//                retire 0, 1 or 2 entries per cycle. Tracks occupancy,
//                full/empty, supports flush, and keeps sticky overflow /
//                underflow error flags. Serves as the per-wavefront
//                instruction/operand buffer between fetch/decode and issue.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    BITS   pointer width; SIZE must equal 2**BITS
//    SIZE   number of entries
//    WIDTH  bits per entry
//  Ports
//    clk            in   clock, all state updates on rising edge
//    rst            in   synchronous active-high reset
//    in_push        in   write request
//    in_push_data   in   data written at tail when the push is accepted
//    in_pop_cnt     in   entries to retire this cycle (0,1,2; 3 is illegal)
//    in_flush       in   discard all entries
//    out_rd_data0   out  entry at head, 0 when out_valid0 is low
//    out_rd_data1   out  entry at head+1, 0 when out_valid1 is low
//    out_valid0     out  at least one entry held
//    out_valid1     out  at least two entries held
//    out_count      out  occupancy, 0..SIZE
//    out_full       out  occupancy equals SIZE
//    out_empty      out  occupancy equals zero
//    out_overflow   out  sticky: a push was dropped
//    out_underflow  out  sticky: an illegal or insufficient pop was rejected
// ============================================================================
module queue_param_fifo_1w_2r #(
    parameter int BITS  = 2,
    parameter int SIZE  = 4,
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_push,
    input  logic [WIDTH-1:0]  in_push_data,
    input  logic [1:0]        in_pop_cnt,
    input  logic              in_flush,
    output logic [WIDTH-1:0]  out_rd_data0,
    output logic [WIDTH-1:0]  out_rd_data1,
    output logic              out_valid0,
    output logic              out_valid1,
    output logic [BITS:0]     out_count,
    output logic              out_full,
    output logic              out_empty,
    output logic              out_overflow,
    output logic              out_underflow
);

    localparam logic [BITS:0]   c_SIZE  = (BITS+1)'(SIZE);
    localparam logic [BITS-1:0] c_ONE   = (BITS)'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem [SIZE];
    logic [BITS-1:0]  r_head;
    logic [BITS-1:0]  r_tail;
    logic [BITS:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    // ------------------------------------------------------------------------
    // Accept/reject decisions, all taken against the count at cycle start
    // ------------------------------------------------------------------------
    logic [BITS:0]    w_pop_ext;
    logic             w_pop_ok;
    logic             w_pop_some;
    logic [BITS:0]    w_pop_acc;
    logic             w_push_acc;
    logic             w_push_rej;
    logic [BITS-1:0]  w_head1;

    always_comb begin
        w_pop_ext  = (BITS+1)'(in_pop_cnt);
        // A pop of 3 is never legal; otherwise it must fit in what is held.
        w_pop_ok   = (in_pop_cnt != 2'd3) && (w_pop_ext <= r_count);
        w_pop_some = w_pop_ok && (in_pop_cnt != 2'd0);
        w_pop_acc  = w_pop_ok ? w_pop_ext : '0;
        // A full queue can still take a push when a slot is freed this cycle.
        w_push_acc = in_push && ((r_count < c_SIZE) || w_pop_some);
        w_push_rej = in_push && !w_push_acc;
        w_head1    = r_head + c_ONE;
    end

    // ------------------------------------------------------------------------
    // Sequential update: rst > flush > pop/push
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else if (in_flush) begin
            // Storage and sticky flags are intentionally preserved.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (!w_pop_ok) begin
                r_underflow <= 1'b1;
            end
            if (w_push_rej) begin
                r_overflow <= 1'b1;
            end
            if (w_push_acc) begin
                r_mem[r_tail] <= in_push_data;
                r_tail        <= r_tail + c_ONE;
            end
            // Truncation to BITS gives the modulo-SIZE wrap for free.
            r_head  <= r_head + w_pop_acc[BITS-1:0];
            r_count <= r_count + (BITS+1)'(w_push_acc) - w_pop_acc;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: purely from registered state, no write-to-read bypass
    // ------------------------------------------------------------------------
    always_comb begin
        out_valid0    = (r_count != '0);
        out_valid1    = (r_count > (BITS+1)'(1));
        out_rd_data0  = out_valid0 ? r_mem[r_head]  : '0;
        out_rd_data1  = out_valid1 ? r_mem[w_head1] : '0;
        out_count     = r_count;
        out_full      = (r_count == c_SIZE);
        out_empty     = (r_count == '0);
        out_overflow  = r_overflow;
        out_underflow = r_underflow;
    end

endmodule
`default_nettype wire

// File: tb/tb_queue_param_fifo_1w_2r.sv
`default_nettype none
// ============================================================================
//  Module      : tb_queue_param_fifo_1w_2r
//  Description : Self-checking bench for queue_param_fifo_1w_2r. Directed
//                scenarios followed by randomized traffic, compared against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_queue_param_fifo_1w_2r;

    localparam int BITS  = 2;
    localparam int SIZE  = 4;
    localparam int WIDTH = 32;

    logic              clk;
    logic              r_rst;
    logic              r_push;
    logic [WIDTH-1:0]  r_push_data;
    logic [1:0]        r_pop_cnt;
    logic              r_flush;
    logic [WIDTH-1:0]  w_rd_data0;
    logic [WIDTH-1:0]  w_rd_data1;
    logic              w_valid0;
    logic              w_valid1;
    logic [BITS:0]     w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_overflow;
    logic              w_underflow;

    queue_param_fifo_1w_2r #(
        .BITS  (BITS),
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) u_dut (
        .clk           (clk),
        .rst           (r_rst),
        .in_push       (r_push),
        .in_push_data  (r_push_data),
        .in_pop_cnt    (r_pop_cnt),
        .in_flush      (r_flush),
        .out_rd_data0  (w_rd_data0),
        .out_rd_data1  (w_rd_data1),
        .out_valid0    (w_valid0),
        .out_valid1    (w_valid1),
        .out_count     (w_count),
        .out_full      (w_full),
        .out_empty     (w_empty),
        .out_overflow  (w_overflow),
        .out_underflow (w_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain list of held entries plus the two sticky flags.
    logic [WIDTH-1:0] m_q[$];
    logic             m_ovf;
    logic             m_udf;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h, required 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic push, input logic [WIDTH-1:0] data,
                                input logic [1:0] pop, input logic flush, input logic rst_i);
        int  cnt;
        bit  pop_ok;
        bit  push_ok;
        if (rst_i) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (flush) begin
            m_q.delete();
        end else begin
            cnt     = m_q.size();
            pop_ok  = (pop != 2'd3) && (int'(pop) <= cnt);
            push_ok = push && ((cnt < SIZE) || (pop_ok && pop != 2'd0));
            if (!pop_ok) m_udf = 1'b1;
            if (pop_ok) begin
                for (int k = 0; k < int'(pop); k++) void'(m_q.pop_front());
            end
            if (push) begin
                if (push_ok) m_q.push_back(data);
                else         m_ovf = 1'b1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        int n;
        n = m_q.size();
        check({tag, ".count"},  32'(w_count),     32'(n));
        check({tag, ".full"},   32'(w_full),      32'(n == SIZE));
        check({tag, ".empty"},  32'(w_empty),     32'(n == 0));
        check({tag, ".valid0"}, 32'(w_valid0),    32'(n >= 1));
        check({tag, ".valid1"}, 32'(w_valid1),    32'(n >= 2));
        check({tag, ".rd0"},    w_rd_data0,       (n >= 1) ? m_q[0] : 32'h0);
        check({tag, ".rd1"},    w_rd_data1,       (n >= 2) ? m_q[1] : 32'h0);
        check({tag, ".ovf"},    32'(w_overflow),  32'(m_ovf));
        check({tag, ".udf"},    32'(w_underflow), 32'(m_udf));
    endtask

    // Apply one cycle of stimulus, advance the model, then check 1 time unit
    // after the edge.
    task automatic step(input string tag, input logic push, input logic [WIDTH-1:0] data,
                        input logic [1:0] pop, input logic flush, input logic rst_i);
        r_push      = push;
        r_push_data = data;
        r_pop_cnt   = pop;
        r_flush     = flush;
        r_rst       = rst_i;
        @(posedge clk);
        model_update(push, data, pop, flush, rst_i);
        #1;
        r_push    = 1'b0;
        r_pop_cnt = 2'd0;
        r_flush   = 1'b0;
        r_rst     = 1'b0;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        step(tag, 1'b0, '0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic push_one(input string tag, input logic [WIDTH-1:0] data);
        step(tag, 1'b1, data, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic pop_n(input string tag, input logic [1:0] n);
        step(tag, 1'b0, '0, n, 1'b0, 1'b0);
    endtask

    initial begin
        r_rst       = 1'b1;
        r_push      = 1'b0;
        r_push_data = '0;
        r_pop_cnt   = 2'd0;
        r_flush     = 1'b0;
        m_ovf       = 1'b0;
        m_udf       = 1'b0;
        #2;

        // Reset state
        do_reset("rst0");
        check("rst0.empty_lit", 32'(w_empty), 32'd1);
        check("rst0.rd0_lit",   w_rd_data0,  32'h0);

        // Fill to full, then drop a fifth push
        for (int i = 0; i < 4; i++) push_one("fill", 32'hA000_0000 + 32'(i));
        check("fill.count_lit", 32'(w_count), 32'd4);
        check("fill.rd0_lit",   w_rd_data0,  32'hA000_0000);
        check("fill.rd1_lit",   w_rd_data1,  32'hA000_0001);
        push_one("ovf", 32'hDEAD_0005);
        check("ovf.flag_lit",   32'(w_overflow), 32'd1);
        check("ovf.count_lit",  32'(w_count),    32'd4);

        // Full queue: push + pop in the same cycle is accepted
        do_reset("rst1");
        for (int i = 0; i < 4; i++) push_one("fill2", 32'hA000_0000 + 32'(i));
        step("pushpop", 1'b1, 32'hB000_0000, 2'd1, 1'b0, 1'b0);
        check("pushpop.rd0_lit", w_rd_data0, 32'hA000_0001);
        check("pushpop.rd1_lit", w_rd_data1, 32'hA000_0002);
        check("pushpop.ovf_lit", 32'(w_overflow), 32'd0);
        pop_n("pop2a", 2'd2);
        check("pop2a.rd0_lit", w_rd_data0, 32'hA000_0003);
        check("pop2a.rd1_lit", w_rd_data1, 32'hB000_0000);
        pop_n("pop2b", 2'd2);
        pop_n("pop2c", 2'd2);
        check("pop2c.count_lit", 32'(w_count), 32'd0);

        // Empty queue: pop rejected, push still accepted
        do_reset("rst2");
        step("emptypop", 1'b1, 32'hC000_0000, 2'd1, 1'b0, 1'b0);
        check("emptypop.udf_lit", 32'(w_underflow), 32'd1);
        check("emptypop.rd0_lit", w_rd_data0, 32'hC000_0000);

        // Insufficient pop, then illegal pop of 3 on a full queue
        pop_n("short", 2'd2);
        check("short.count_lit", 32'(w_count), 32'd1);
        do_reset("rst3");
        for (int i = 0; i < 4; i++) push_one("fill3", 32'h3300_0000 + 32'(i));
        pop_n("pop3", 2'd3);
        check("pop3.udf_lit",   32'(w_underflow), 32'd1);
        check("pop3.count_lit", 32'(w_count),     32'd4);

        // Flush dominates push/pop
        do_reset("rst4");
        for (int i = 0; i < 3; i++) push_one("fill4", 32'h4400_0000 + 32'(i));
        step("flush", 1'b1, 32'hEEEE_EEEE, 2'd2, 1'b1, 1'b0);
        check("flush.empty_lit", 32'(w_empty), 32'd1);
        push_one("postflush", 32'hD000_0000);
        check("postflush.rd0_lit", w_rd_data0, 32'hD000_0000);

        // Mid-stream reset with push asserted, flags set beforehand
        pop_n("setudf", 2'd3);
        for (int i = 0; i < 4; i++) push_one("fill5", 32'h5500_0000 + 32'(i));
        step("midrst", 1'b1, 32'h6600_0000, 2'd1, 1'b0, 1'b1);
        check("midrst.ovf_lit", 32'(w_overflow),  32'd0);
        check("midrst.udf_lit", 32'(w_underflow), 32'd0);
        check("midrst.cnt_lit", 32'(w_count),     32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic       push;
            logic [1:0] pop;
            logic       flush;
            logic       rst_i;
            int         sel;
            push  = ($urandom_range(0, 99) < 60);
            sel   = $urandom_range(0, 99);
            pop   = (sel < 35) ? 2'd0 : (sel < 70) ? 2'd1 : (sel < 97) ? 2'd2 : 2'd3;
            flush = ($urandom_range(0, 99) < 4);
            rst_i = ($urandom_range(0, 199) < 2);
            step("rand", push, $urandom, pop, flush, rst_i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
